// File: rtl/hl_weight_loader.sv
// Streams 65 signed weights (50 hidden + 15 output) into the shared weight RAM, one
// registered write per accepted word. Optional checksum stage: define HL_WEIGHT_CHECKSUM_EN.
module hl_weight_loader #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned N_HIDDEN = 50,
  parameter int unsigned N_OUTPUT = 15
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              layer_sel,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_HIDDEN + N_OUTPUT - 1);
  localparam logic [CNT_W-1:0] HID_LIM  = CNT_W'(N_HIDDEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              accept;
  logic              s_ready_d, we_d, layer_sel_d, busy_d, done_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] wdata_d;
  logic [CNT_W-1:0]  count_d;

`ifdef HL_WEIGHT_CHECKSUM_EN
  logic [SUM_W-1:0] sum, sum_d;
  logic             chk_err_d;
  logic [SUM_W-1:0] data_sext, data_zext;

  assign data_sext = {{(SUM_W-DATA_W){s_data[DATA_W-1]}}, s_data};
  assign data_zext = {{(SUM_W-DATA_W){1'b0}}, s_data};
`endif

  assign accept = s_valid && s_ready;

  // State and all registered outputs; the pending write is dropped by Rst.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      WE        <= 1'b0;
      address   <= '0;
      wdata     <= '0;
      layer_sel <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      s_ready   <= s_ready_d;
      WE        <= we_d;
      address   <= address_d;
      wdata     <= wdata_d;
      layer_sel <= layer_sel_d;
      count     <= count_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef HL_WEIGHT_CHECKSUM_EN
  always_ff @(posedge Clock) begin
    if (Rst) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      sum     <= sum_d;
      chk_err <= chk_err_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  // Next-state and next-output logic; abort always has priority over start.
  always_comb begin
    state_d     = state;
    we_d        = 1'b0;
    address_d   = address;
    wdata_d     = wdata;
    layer_sel_d = layer_sel;
    count_d     = count;
`ifdef HL_WEIGHT_CHECKSUM_EN
    sum_d       = sum;
    chk_err_d   = chk_err;
`endif

    // count doubles as the write index: both advance together on every accept.
    if (accept && state == LOAD) begin
      we_d        = 1'b1;
      address_d   = ADDR_W'(count);
      wdata_d     = s_data;
      layer_sel_d = (count >= HID_LIM);
      count_d     = count + CNT_W'(1);
`ifdef HL_WEIGHT_CHECKSUM_EN
      sum_d       = sum + data_sext;
`endif
    end

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          count_d = '0;
`ifdef HL_WEIGHT_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && count == LAST_IDX) begin
`ifdef HL_WEIGHT_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef HL_WEIGHT_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          chk_err_d = (data_zext != sum);
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = LOAD;
          count_d = '0;
`ifdef HL_WEIGHT_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LOAD) || (state_d == CHECK);
    busy_d    = (state_d == LOAD) || (state_d == CHECK);
    done_d    = (state_d == DONE);
  end

endmodule
